// File: rtl/autosym_pkg.sv
// rtl/autosym_pkg.sv - shared types, defaults and helpers for the autosymmetry scanner
//
// Purpose: FSM state encoding, default geometry and the one-hot to index
// helper used to turn the linear-space size into the autosymmetry degree.
// Ports: none (package).
// Optional feature macro: AUTOSYM_EARLY_ABORT_EN (consumed by autosym_space_scan).

package autosym_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } autosym_state_e;

    localparam int N_IN_DEF   = 8;
    localparam int LOAD_W_DEF = 32;

    // Index of the single set bit; the linear space size is always a power of two.
    function automatic logic [7:0] log2_onehot(input logic [63:0] v);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) begin
                r = 8'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/autosym_tt_mem.sv
// rtl/autosym_tt_mem.sv - truth-table bit array with word write port and two bit read ports
//
// Purpose: holds the 2^N_IN-bit truth table of f. Loaded LOAD_W bits at a
// time; read combinationally at two addresses per cycle (x and x^a).
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high clear of the table
//   wr_en_i             write one word
//   wr_addr_i [AW]      word index; bit i of word w is f(w*LOAD_W + i)
//   wr_data_i [LOAD_W]  word data
//   rd0_addr_i, rd1_addr_i [N_IN]  bit read addresses
//   rd0_o, rd1_o        f at those addresses

module autosym_tt_mem #(
    parameter int   N_IN   = 8,
    parameter int   LOAD_W = 32,
    localparam int  LB     = $clog2(LOAD_W),
    localparam int  AW     = N_IN - LB,
    localparam int  DEPTH  = 1 << N_IN
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [LOAD_W-1:0] wr_data_i,
    input  logic [N_IN-1:0]   rd0_addr_i,
    input  logic [N_IN-1:0]   rd1_addr_i,
    output logic              rd0_o,
    output logic              rd1_o
);

    logic [DEPTH-1:0] mem_q;
    logic [N_IN-1:0]  wr_base;

    assign wr_base = {wr_addr_i, {LB{1'b0}}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_base +: LOAD_W] <= wr_data_i;
        end
    end

    assign rd0_o = mem_q[rd0_addr_i];
    assign rd1_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/autosym_space_scan.sv
// rtl/autosym_space_scan.sv - sequential linear-structure scanner for single-output functions
//
// Purpose: after the truth table is loaded and start is pulsed, tests every
// candidate a for f(x) == f(x^a) over all x, streams passing vectors on the
// ls_* handshake, then reports the linear space size and autosymmetry degree.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   tt_wr_en/addr/data          truth-table word load (IDLE only)
//   start                       begin scan (ignored if tt_wr_en is also high)
//   busy, done                  scan in progress, one-cycle end pulse
//   ls_valid/ls_ready/ls_vec    linear-structure output stream
//   ls_count, degree            space size (includes a=0) and log2 of it
// Optional feature macro: AUTOSYM_EARLY_ABORT_EN leaves a candidate on the
// cycle after its first mismatch instead of sweeping all x.

module autosym_space_scan
    import autosym_pkg::*;
#(
    parameter int  N_IN   = N_IN_DEF,
    parameter int  LOAD_W = LOAD_W_DEF,
    localparam int AW     = N_IN - $clog2(LOAD_W),
    localparam int DW     = $clog2(N_IN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tt_wr_en,
    input  logic [AW-1:0]     tt_wr_addr,
    input  logic [LOAD_W-1:0] tt_wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ls_valid,
    input  logic              ls_ready,
    output logic [N_IN-1:0]   ls_vec,
    output logic [N_IN:0]     ls_count,
    output logic [DW-1:0]     degree
);

    autosym_state_e  state_q;
    logic [N_IN-1:0] a_q;
    logic [N_IN-1:0] x_q;
    logic            fail_q;
    logic            busy_q;
    logic            done_q;
    logic            ls_valid_q;
    logic [N_IN-1:0] ls_vec_q;
    logic [N_IN:0]   ls_count_q;
    logic [DW-1:0]   degree_q;

    logic            wr_en;
    logic            rd_x;
    logic            rd_xa;
    logic            mismatch;
    logic            fail_now;
    logic            a_last;
    logic            x_last;
    logic            cand_end;
    logic [N_IN:0]   cnt_inc;
    logic [DW-1:0]   deg_cur;
    logic [DW-1:0]   deg_inc;

    // The table is frozen while a scan runs so results stay self-consistent.
    assign wr_en = tt_wr_en && (state_q == IDLE);

    autosym_tt_mem #(
        .N_IN   (N_IN),
        .LOAD_W (LOAD_W)
    ) u_tt_mem (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (tt_wr_addr),
        .wr_data_i  (tt_wr_data),
        .rd0_addr_i (x_q),
        .rd1_addr_i (x_q ^ a_q),
        .rd0_o      (rd_x),
        .rd1_o      (rd_xa)
    );

    assign mismatch = rd_x ^ rd_xa;
    assign fail_now = fail_q | mismatch;
    assign a_last   = (a_q == {N_IN{1'b1}});
    assign x_last   = (x_q == {N_IN{1'b1}});

`ifdef AUTOSYM_EARLY_ABORT_EN
    assign cand_end = x_last || mismatch;
`else
    assign cand_end = x_last;
`endif

    // Degree is taken from the count as it will stand in DONE: incremented
    // when the final candidate is emitted, unchanged when it failed.
    assign cnt_inc = ls_count_q + 1'b1;
    assign deg_cur = DW'(log2_onehot(64'(ls_count_q)));
    assign deg_inc = DW'(log2_onehot(64'(cnt_inc)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            x_q        <= '0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ls_valid_q <= 1'b0;
            ls_vec_q   <= '0;
            ls_count_q <= '0;
            degree_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !tt_wr_en) begin
                        state_q    <= EMIT;
                        a_q        <= '0;
                        x_q        <= '0;
                        fail_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        ls_valid_q <= 1'b1;
                        ls_vec_q   <= '0;
                        ls_count_q <= '0;
                        degree_q   <= '0;
                    end
                end
                EMIT: begin
                    if (ls_ready) begin
                        ls_valid_q <= 1'b0;
                        ls_count_q <= cnt_inc;
                        if (a_last) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            degree_q <= deg_inc;
                        end else begin
                            state_q <= SCAN;
                            a_q     <= a_q + 1'b1;
                            x_q     <= '0;
                            fail_q  <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (cand_end) begin
                        if (!fail_now) begin
                            state_q    <= EMIT;
                            ls_valid_q <= 1'b1;
                            ls_vec_q   <= a_q;
                        end else if (a_last) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            degree_q <= deg_cur;
                        end else begin
                            a_q    <= a_q + 1'b1;
                            x_q    <= '0;
                            fail_q <= 1'b0;
                        end
                    end else begin
                        x_q    <= x_q + 1'b1;
                        fail_q <= fail_now;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ls_valid = ls_valid_q;
    assign ls_vec   = ls_vec_q;
    assign ls_count = ls_count_q;
    assign degree   = degree_q;

endmodule

// File: tb/tb_autosym_space_scan.sv
// tb/tb_autosym_space_scan.sv - directed self-checking bench for autosym_space_scan

module tb_autosym_space_scan;

    localparam int N  = 6;
    localparam int LW = 16;
    localparam int AW = N - $clog2(LW);
    localparam int DW = $clog2(N + 1);
    localparam int NW = 1 << AW;
    localparam int SZ = 1 << N;
    localparam int BOUND = 20000;

    logic          clk;
    logic          rst;
    logic          tt_wr_en;
    logic [AW-1:0] tt_wr_addr;
    logic [LW-1:0] tt_wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          ls_valid;
    logic          ls_ready;
    logic [N-1:0]  ls_vec;
    logic [N:0]    ls_count;
    logic [DW-1:0] degree;

    autosym_space_scan #(
        .N_IN   (N),
        .LOAD_W (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tt_wr_en   (tt_wr_en),
        .tt_wr_addr (tt_wr_addr),
        .tt_wr_data (tt_wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .ls_valid   (ls_valid),
        .ls_ready   (ls_ready),
        .ls_vec     (ls_vec),
        .ls_count   (ls_count),
        .degree     (degree)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SZ-1:0] tt_img;
    int            vq[$];
    bit            rdy_mode = 1'b0;
    int            ph = 0;
    bit            pv_valid = 1'b0;
    bit            pv_hs    = 1'b0;
    bit [N-1:0]    pv_vec   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer: drives ls_ready, records handshakes, checks stall stability.
    always @(negedge clk) begin
        if (rdy_mode) begin
            ph = (ph + 1) % 3;
            ls_ready = (ph == 0);
        end else begin
            ls_ready = 1'b1;
        end
        if (pv_valid && !pv_hs) begin
            chk("valid_hold", ls_valid, 1);
            chk("vec_stable", ls_vec, pv_vec);
        end
        if (ls_valid && ls_ready) vq.push_back(int'(ls_vec));
        pv_valid = ls_valid;
        pv_hs    = ls_valid && ls_ready;
        pv_vec   = ls_vec;
    end

    task automatic load_all(input logic [LW-1:0] d);
        for (int w = 0; w < NW; w++) begin
            @(negedge clk);
            tt_wr_en   = 1'b1;
            tt_wr_addr = AW'(w);
            tt_wr_data = d;
            tt_img[w*LW +: LW] = d;
        end
        @(negedge clk);
        tt_wr_en = 1'b0;
    endtask

    // Returns posedges from the start-sampling edge up to the edge that raised done.
    task automatic run_scan(input bit disturb, output int cyc);
        int  n;
        bit  seen;
        vq.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk("busy_after_start", busy, 1);
        seen = 1'b0;
        while (n < BOUND && !seen) begin
            @(negedge clk);
            n++;
            if (disturb && n == 5) begin
                tt_wr_en   = 1'b1;
                tt_wr_addr = AW'(1);
                tt_wr_data = '1;
                start      = 1'b1;
            end else if (disturb && n == 9) begin
                tt_wr_en = 1'b0;
                start    = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        cyc = n;
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic check_result(input string tag, input int exp_cnt, input int exp_deg);
        int  idx;
        int  m;
        bit  ok;
        idx = 0;
        m   = 0;
        for (int a = 0; a < SZ; a++) begin
            ok = 1'b1;
            for (int x = 0; x < SZ; x++) begin
                if (tt_img[x] != tt_img[x ^ a]) ok = 1'b0;
            end
            if (ok) begin
                if (idx >= vq.size() || vq[idx] != a) m++;
                idx++;
            end
        end
        chk({tag, "_nvec"}, vq.size(), exp_cnt);
        chk({tag, "_vecs"}, m, 0);
        chk({tag, "_count"}, ls_count, exp_cnt);
        chk({tag, "_degree"}, degree, exp_deg);
    endtask

    initial begin
        int  cyc;
        int  w;
        bit  seen;
        rst        = 1'b1;
        tt_wr_en   = 1'b0;
        tt_wr_addr = '0;
        tt_wr_data = '0;
        start      = 1'b0;
        tt_img     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", ls_valid, 0);
        chk("rst_vec", ls_vec, 0);
        chk("rst_count", ls_count, 0);
        chk("rst_degree", degree, 0);
        chk("rst_mem", dut.u_tt_mem.mem_q, 0);

        // f = 0: every a is a linear structure, no candidate can abort early.
        run_scan(1'b0, cyc);
        check_result("f0", 64, 6);
        chk("f0_cycles", cyc, 1 + 64 + (SZ - 1) * SZ);

        // f = x0
        load_all(16'hAAAA);
        run_scan(1'b0, cyc);
        check_result("x0", 32, 5);
`ifdef AUTOSYM_EARLY_ABORT_EN
        chk("x0_cycles_lt", cyc < 1 + 32 + (SZ - 1) * SZ, 1);
`else
        chk("x0_cycles", cyc, 1 + 32 + (SZ - 1) * SZ);
`endif

        // f = x0 & x1
        load_all(16'h8888);
        run_scan(1'b0, cyc);
        check_result("and", 16, 4);
`ifdef AUTOSYM_EARLY_ABORT_EN
        chk("and_cycles_lt", cyc < 1 + 16 + (SZ - 1) * SZ, 1);
`else
        chk("and_cycles", cyc, 1 + 16 + (SZ - 1) * SZ);
`endif

        // f = x0 ^ x1 with a consumer ready one cycle in three
        load_all(16'h6666);
        rdy_mode = 1'b1;
        run_scan(1'b0, cyc);
        rdy_mode = 1'b0;
        check_result("xor", 32, 5);

        // Writes and start while busy are ignored
        run_scan(1'b1, cyc);
        check_result("busy_ign", 32, 5);
        chk("busy_mem", dut.u_tt_mem.mem_q, tt_img);

        // start together with a write in IDLE: write lands, start dropped
        @(negedge clk);
        tt_wr_en   = 1'b1;
        tt_wr_addr = AW'(2);
        tt_wr_data = 16'h1234;
        start      = 1'b1;
        tt_img[2*LW +: LW] = 16'h1234;
        @(negedge clk);
        tt_wr_en = 1'b0;
        start    = 1'b0;
        chk("wr_start_busy", busy, 0);
        chk("wr_start_valid", ls_valid, 0);
        chk("wr_start_mem", dut.u_tt_mem.mem_q, tt_img);

        // Reset in the middle of scanning candidate 40
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (w < BOUND && !(dut.a_q == N'(40) && !ls_valid)) begin
            @(negedge clk);
            w++;
        end
        chk("reach_a40", w < BOUND, 1);
        rst = 1'b1;
        tt_img = '0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_valid", ls_valid, 0);
        chk("mid_vec", ls_vec, 0);
        chk("mid_count", ls_count, 0);
        chk("mid_degree", degree, 0);
        chk("mid_mem", dut.u_tt_mem.mem_q, 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("mid_no_done", seen, 0);
        load_all(16'hAAAA);
        run_scan(1'b0, cyc);
        check_result("post_rst", 32, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
